vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single-port 16 KB video RAM between the scanline fetch engine (read-only) and the Z80-side CPU port (read/write).
- Scheduling is driven by the video timing generator's hpos/hblank/vblank outputs.
  - During active display, video owns 3 of every 4 cycles.
  - During blanking, the CPU has priority.
  - A starvation counter bounds CPU latency in all cases.
- Sits between the timing generator, the line renderer and the CPU bus bridge.

Parameters:
- ADDR_W, 14, VRAM address width
- DATA_W, 8, VRAM data width
- MAX_WAIT, 6, cycles a pending CPU request may be refused before it is forced through (1..15)

Ports:
- clk  in  1  pixel clock (25.175/28.636 MHz)
- reset  in  1  asynchronous, active-high reset
- hpos  in  10  horizontal counter from timing generator
- hblank  in  1  horizontal blank
- vblank  in  1  vertical blank
- vid_req  in  1  video fetch request (level)
- vid_addr  in  ADDR_W  video fetch address
- vid_ack  out  1  video request granted this cycle (combinational)
- vid_rdvalid  out  1  vid_rddata valid (1 cycle after vid_ack)
- vid_rddata  out  DATA_W  video read data
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_wren  in  1  1=write, 0=read; stable while cpu_req
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req
- cpu_wrdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle pulse; access complete, read data valid
- cpu_rddata  out  DATA_W  CPU read data, held until next CPU read completes
- vram_addr  out  ADDR_W  to BRAM (BRAM registers address)
- vram_wren  out  1  BRAM write enable
- vram_wrdata  out  DATA_W  BRAM write data
- vram_rddata  in  DATA_W  BRAM read data, 1 cycle after address

Behaviour:
Reset and enable:
- q_run flop: cleared by reset, set on the first clk edge after reset deasserts.
- While !q_run, no grants: vid_ack=0, vram_wren=0, vram_addr=0.
- Reset values: cpu_ack=0, vid_rdvalid=0, cpu_rddata=0, q_owner=NONE, q_wait=0.

Per-cycle arbitration (when q_run):
- cpu_elig = cpu_req && !cpu_ack. This blocks re-granting a request still held in its ack cycle, so the CPU gets at most 1 access per 2 cycles.
- cpu_first if any of:
  - hblank || vblank
  - hpos[1:0]==3
  - q_wait==MAX_WAIT
- Otherwise video first.
- Grant the first-priority requester if it is requesting, else the other if it is requesting, else none.

Grant outputs:
- Grant VID: vid_ack=1, vram_addr=vid_addr, vram_wren=0.
- Grant CPU: vram_addr=cpu_addr, vram_wren=cpu_wren, vram_wrdata=cpu_wrdata.
- No grant: vram_addr=vid_addr, vram_wren=0.

Response (registered):
- q_owner <= granted requester.
- Cycle after a VID grant: vid_rdvalid=1, vid_rddata=vram_rddata.
- Cycle after a CPU grant: cpu_ack=1. For reads, cpu_rddata <= vram_rddata is captured at that edge, so it is valid during the ack cycle.
- Latency: CPU request to ack is 2 cycles minimum, MAX_WAIT+2 maximum. Video fetch to data is 1 cycle.

Starvation counter q_wait (4 bit):
- Increments when cpu_elig && no CPU grant, saturating at MAX_WAIT.
- Cleared on CPU grant or when cpu_req=0.

Edge cases:
- A CPU write and a video read to the same address in adjacent cycles: BRAM ordering applies; the arbiter adds no forwarding.
- Dropping cpu_req before ack is illegal; behaviour is unspecified, but there must be no lockup, and q_wait clears.
- Reset mid-access discards any pending ack/rdvalid.

Decomposition:
- Package vram_arb_pkg:
  - owner encoding: OWN_NONE=2'd0, OWN_VID=2'd1, OWN_CPU=2'd2
  - ADDR_W/DATA_W defaults
  - CPU_SLOT=2'd3
- No sub-module. Priority select and starvation counter are small enough to stay inline.

Test Plan:
- Active region, vid_req held high, cpu_req read at hpos=100 (slot 0) -> cpu_ack at hpos=104 (granted in slot 3, hpos=103); vid_rdvalid high every cycle except hpos=104.
- hblank=1, vid_req and cpu_req both high -> CPU granted the first cycle, video the next; CPU re-granted no sooner than 2 cycles later.
- MAX_WAIT=2, forced hpos[1:0]!=3 with vid_req high -> CPU granted when q_wait reaches 2; request-to-ack latency is 4 cycles.
- CPU write 0xA5 to 0x1234, then CPU read of 0x1234 -> cpu_rddata=0xA5 on the second ack; vram_wren high exactly 1 cycle.
- Video fetch vid_addr=0x3FFF with BRAM preloaded 0x5A -> vid_ack same cycle, vid_rdvalid+0x5A next cycle.
- Assert reset during a pending CPU grant -> cpu_ack and vid_rdvalid 0 immediately; no grant until the 2nd edge after release.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared definitions for the video RAM arbiter: owner encoding,
// default bus widths and the CPU-reserved hpos slot.
`timescale 1ns/1ps
package vram_arb_pkg;

    localparam int VRAM_ADDR_W = 14;
    localparam int VRAM_DATA_W = 8;

    // hpos[1:0] value in which the CPU has priority during active display
    localparam logic [1:0] CPU_SLOT = 2'd3;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between the scanline fetch engine and the CPU
// bridge. Video owns three of every four active-display cycles, the CPU wins
// during blanking, and a starvation counter forces a waiting CPU access
// through after MAX_WAIT refusals.
`timescale 1ns/1ps
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W   = VRAM_ADDR_W,
    parameter int DATA_W   = VRAM_DATA_W,
    parameter int MAX_WAIT = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        hpos,
    input  logic              hblank,
    input  logic              vblank,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic              vid_rdvalid,
    output logic [DATA_W-1:0] vid_rddata,
    input  logic              cpu_req,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wrdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rddata,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_wren,
    output logic [DATA_W-1:0] vram_wrdata,
    input  logic [DATA_W-1:0] vram_rddata
);

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic              q_run;
    owner_t            q_owner;
    logic [3:0]        q_wait;
    logic              r_cpu_rd;
    logic [DATA_W-1:0] r_cpu_rddata;

    owner_t            w_grant;
    logic              w_slot;
    logic              w_cpu_elig;
    logic              w_cpu_first;

    // Whole-vector mask keeps every hpos bit in the expression; only the
    // low two bits select the slot.
    assign w_slot      = ((hpos & 10'h3) == {8'd0, CPU_SLOT});

    // A request still held during its own ack cycle is not re-granted.
    assign w_cpu_elig  = cpu_req && !cpu_ack;
    assign w_cpu_first = hblank || vblank || w_slot || (q_wait == WAIT_LIM);

    assign cpu_ack     = (q_owner == OWN_CPU);
    assign vid_rdvalid = (q_owner == OWN_VID);

    // BRAM data for a grant arrives the cycle after it, which is exactly the
    // rdvalid/ack cycle, so both paths see vram_rddata directly then.
    assign vid_rddata  = vram_rddata;
    assign cpu_rddata  = (cpu_ack && r_cpu_rd) ? vram_rddata : r_cpu_rddata;

    // Enable flop: no grants until the first edge after reset releases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q_run <= 1'b0;
        else       q_run <= 1'b1;
    end

    // Priority select: preferred requester first, otherwise the other one.
    always_comb begin
        w_grant = OWN_NONE;
        if (q_run) begin
            if (w_cpu_first) begin
                if (w_cpu_elig)   w_grant = OWN_CPU;
                else if (vid_req) w_grant = OWN_VID;
            end else begin
                if (vid_req)         w_grant = OWN_VID;
                else if (w_cpu_elig) w_grant = OWN_CPU;
            end
        end
    end

    // Drive the BRAM port and the video ack from the current grant.
    always_comb begin
        vid_ack     = 1'b0;
        vram_addr   = '0;
        vram_wren   = 1'b0;
        vram_wrdata = cpu_wrdata;
        if (q_run) vram_addr = vid_addr;
        if (w_grant == OWN_CPU) begin
            vram_addr = cpu_addr;
            vram_wren = cpu_wren;
        end
        if (w_grant == OWN_VID) vid_ack = 1'b1;
    end

    // Remember who owned the port so the response lands one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_owner  <= OWN_NONE;
            r_cpu_rd <= 1'b0;
        end else begin
            q_owner  <= w_grant;
            r_cpu_rd <= (w_grant == OWN_CPU) && !cpu_wren;
        end
    end

    // Starvation counter: counts refused cycles of an eligible CPU request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_wait <= 4'd0;
        end else if (!cpu_req || (w_grant == OWN_CPU)) begin
            q_wait <= 4'd0;
        end else if (w_cpu_elig && (q_wait != WAIT_LIM)) begin
            q_wait <= q_wait + 4'd1;
        end
    end

    // Hold the last CPU read result until the next CPU read completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   r_cpu_rddata <= '0;
        else if (cpu_ack && r_cpu_rd) r_cpu_rddata <= vram_rddata;
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous BRAM.
`timescale 1ns/1ps
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hpos;
    logic        hblank, vblank;
    logic        vid_req;
    logic [13:0] vid_addr;
    logic        cpu_req, cpu_wren;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wrdata;
    logic [7:0]  vram_rddata;
    logic        vid_ack, vid_rdvalid, cpu_ack, vram_wren;
    logic [7:0]  vid_rddata, cpu_rddata, vram_wrdata;
    logic [13:0] vram_addr;

    // second instance with a short starvation limit
    logic        d2_vid_req, d2_cpu_req;
    logic [9:0]  d2_hpos;
    logic [13:0] d2_addr;
    logic [7:0]  d2_rddata;
    logic        d2_vid_ack, d2_vid_rdvalid, d2_cpu_ack, d2_vram_wren;
    logic [7:0]  d2_vid_rddata, d2_cpu_rddata, d2_vram_wrdata;
    logic [13:0] d2_vram_addr;

    logic [7:0]  mem [0:16383];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(14), .DATA_W(8), .MAX_WAIT(6)) dut (
        .clk(clk), .reset(reset), .hpos(hpos), .hblank(hblank), .vblank(vblank),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_rdvalid(vid_rdvalid), .vid_rddata(vid_rddata),
        .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr),
        .cpu_wrdata(cpu_wrdata), .cpu_ack(cpu_ack), .cpu_rddata(cpu_rddata),
        .vram_addr(vram_addr), .vram_wren(vram_wren), .vram_wrdata(vram_wrdata),
        .vram_rddata(vram_rddata)
    );

    vram_arbiter #(.ADDR_W(14), .DATA_W(8), .MAX_WAIT(2)) dut2 (
        .clk(clk), .reset(reset), .hpos(d2_hpos), .hblank(1'b0), .vblank(1'b0),
        .vid_req(d2_vid_req), .vid_addr(d2_addr), .vid_ack(d2_vid_ack),
        .vid_rdvalid(d2_vid_rdvalid), .vid_rddata(d2_vid_rddata),
        .cpu_req(d2_cpu_req), .cpu_wren(1'b0), .cpu_addr(d2_addr),
        .cpu_wrdata(8'h00), .cpu_ack(d2_cpu_ack), .cpu_rddata(d2_cpu_rddata),
        .vram_addr(d2_vram_addr), .vram_wren(d2_vram_wren), .vram_wrdata(d2_vram_wrdata),
        .vram_rddata(d2_rddata)
    );

    // synchronous BRAM: registers the address, data valid the next cycle
    always @(posedge clk) begin
        if (vram_wren) mem[vram_addr] <= vram_wrdata;
        vram_rddata <= mem[vram_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to 2 time units after the next rising edge
    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[14'h0100] = 8'h77;
        mem[14'h3FFF] = 8'h5A;
        reset = 1'b1; hpos = 10'd0; hblank = 1'b0; vblank = 1'b0;
        vid_req = 1'b0; vid_addr = 14'h0040;
        cpu_req = 1'b0; cpu_wren = 1'b0; cpu_addr = 14'h0100; cpu_wrdata = 8'h00;
        d2_vid_req = 1'b1; d2_cpu_req = 1'b0; d2_hpos = 10'd0; d2_addr = 14'h0200;
        d2_rddata = 8'h00;

        // reset state
        repeat (2) @(posedge clk);
        #2;
        vid_req = 1'b1;
        #1;
        check_eq("rst_cpu_ack", cpu_ack, 0);
        check_eq("rst_vid_rdvalid", vid_rdvalid, 0);
        check_eq("rst_cpu_rddata", cpu_rddata, 0);
        check_eq("rst_vid_ack", vid_ack, 0);
        check_eq("rst_vram_addr", vram_addr, 0);
        check_eq("rst_vram_wren", vram_wren, 0);
        reset = 1'b0;
        #1;
        check_eq("norun_vid_ack", vid_ack, 0);
        next_cyc();
        #1;
        check_eq("run_vid_ack", vid_ack, 1);

        // active display: CPU read waits for slot 3
        for (int h = 96; h <= 105; h++) begin
            next_cyc();
            hpos = 10'(h);
            cpu_req = (h >= 100 && h <= 104);
            #1;
            check_eq($sformatf("act_vid_ack_%0d", h), vid_ack, (h != 103));
            check_eq($sformatf("act_cpu_ack_%0d", h), cpu_ack, (h == 104));
            check_eq($sformatf("act_vid_rdvalid_%0d", h), vid_rdvalid, (h != 104));
            if (h == 103) check_eq("act_vram_addr", vram_addr, 14'h0100);
            if (h == 104) check_eq("act_cpu_rddata", cpu_rddata, 8'h77);
        end

        // starvation with MAX_WAIT=6, slot 3 never reached
        next_cyc();
        hpos = 10'd0; cpu_req = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            next_cyc();
            cpu_req = 1'b1;
            #1;
            check_eq($sformatf("st6_vid_ack_%0d", c), vid_ack, (c != 6));
            check_eq($sformatf("st6_cpu_ack_%0d", c), cpu_ack, (c == 7));
        end
        next_cyc();
        cpu_req = 1'b0;

        // blanking: CPU first, video next, CPU again two cycles later
        hblank = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            next_cyc();
            cpu_req = (c < 4);
            #1;
            check_eq($sformatf("blk_vid_ack_%0d", c), vid_ack, (c == 1 || c == 3 || c == 4));
            check_eq($sformatf("blk_cpu_ack_%0d", c), cpu_ack, (c == 1 || c == 3));
        end

        // write 0xA5 to 0x1234, then read it back
        vid_req = 1'b0;
        next_cyc();
        cpu_req = 1'b1; cpu_wren = 1'b1; cpu_addr = 14'h1234; cpu_wrdata = 8'hA5;
        #1;
        check_eq("wr_vram_wren", vram_wren, 1);
        check_eq("wr_vram_addr", vram_addr, 14'h1234);
        check_eq("wr_vram_wrdata", vram_wrdata, 8'hA5);
        next_cyc();
        #1;
        check_eq("wr_cpu_ack", cpu_ack, 1);
        check_eq("wr_wren_ack_cycle", vram_wren, 0);
        next_cyc();
        cpu_req = 1'b0; cpu_wren = 1'b0;
        #1;
        check_eq("wr_wren_after", vram_wren, 0);
        next_cyc();
        cpu_req = 1'b1;
        #1;
        check_eq("rd_vram_wren", vram_wren, 0);
        check_eq("rd_vram_addr", vram_addr, 14'h1234);
        next_cyc();
        #1;
        check_eq("rd_cpu_ack", cpu_ack, 1);
        check_eq("rd_cpu_rddata", cpu_rddata, 8'hA5);
        next_cyc();
        cpu_req = 1'b0;
        #1;
        check_eq("rd_cpu_ack_gone", cpu_ack, 0);
        check_eq("rd_cpu_rddata_held", cpu_rddata, 8'hA5);

        // video fetch at the top address
        hblank = 1'b0; hpos = 10'd0;
        next_cyc();
        vid_req = 1'b1; vid_addr = 14'h3FFF;
        #1;
        check_eq("vf_vid_ack", vid_ack, 1);
        check_eq("vf_vram_addr", vram_addr, 14'h3FFF);
        next_cyc();
        vid_req = 1'b0;
        #1;
        check_eq("vf_vid_rdvalid", vid_rdvalid, 1);
        check_eq("vf_vid_rddata", vid_rddata, 8'h5A);

        // MAX_WAIT=2 instance: grant when the counter reaches 2
        for (int c = 0; c <= 3; c++) begin
            next_cyc();
            d2_cpu_req = 1'b1;
            #1;
            check_eq($sformatf("st2_vid_ack_%0d", c), d2_vid_ack, (c != 2));
            check_eq($sformatf("st2_cpu_ack_%0d", c), d2_cpu_ack, (c == 3));
        end
        next_cyc();
        d2_cpu_req = 1'b0;

        // reset during a pending CPU grant
        hblank = 1'b1; vid_req = 1'b1; cpu_addr = 14'h0100;
        next_cyc();
        #1;
        check_eq("rs_pre_vid_ack", vid_ack, 1);
        next_cyc();
        cpu_req = 1'b1;
        #1;
        check_eq("rs_grant_addr", vram_addr, 14'h0100);
        check_eq("rs_pre_rdvalid", vid_rdvalid, 1);
        reset = 1'b1;
        #1;
        check_eq("rs_rdvalid_cleared", vid_rdvalid, 0);
        check_eq("rs_vid_ack_held", vid_ack, 0);
        check_eq("rs_vram_addr_zero", vram_addr, 0);
        next_cyc();
        #1;
        check_eq("rs_cpu_ack_dropped", cpu_ack, 0);
        reset = 1'b0;
        #1;
        check_eq("rs_norun_vid_ack", vid_ack, 0);
        check_eq("rs_norun_wren", vram_wren, 0);
        next_cyc();
        #1;
        check_eq("rs_e1_cpu_ack", cpu_ack, 0);
        check_eq("rs_e1_grant_addr", vram_addr, 14'h0100);
        next_cyc();
        #1;
        check_eq("rs_e2_cpu_ack", cpu_ack, 1);
        next_cyc();
        cpu_req = 1'b0;
        next_cyc();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
